// File: rtl/dlx_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller for the DLX core.
// Owns the PC, IR and the 32x32 register file; the ALU is external.
module dlx_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [3:0]  alu_I,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic        alu_ex,
    input  logic [31:0] alu_res,
    input  logic        alu_carry,
    input  logic        alu_z,
    output logic        flag_c,
    output logic        flag_z,
    output logic        halted,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir;
    logic [31:0] r_regs [32];
    logic [3:0]  r_alu_I;
    logic [31:0] r_op1, r_op2;
    logic        r_flag_c, r_flag_z, r_illegal;

    logic [5:0]  w_opc;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [10:0] w_func;
    logic [31:0] w_rs1_val, w_rs2_val, w_sext16, w_zext16, w_sext26, w_pc4;
    logic        w_is_alu, w_is_br, w_is_ill;
    logic [3:0]  w_I;
    logic [31:0] w_op1, w_op2, w_pc_next;

    assign w_opc     = r_ir[31:26];
    assign w_rs1     = r_ir[25:21];
    assign w_rs2     = r_ir[20:16];
    assign w_func    = r_ir[10:0];
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];
    assign w_sext16  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zext16  = {16'h0000, r_ir[15:0]};
    assign w_sext26  = {{6{r_ir[25]}}, r_ir[25:0]};
    assign w_pc4     = r_pc + 32'd4;

    // Decode is purely from IR; it is consumed in DECODE and rd again in WB.
    always_comb begin
        w_is_alu  = 1'b0;
        w_is_br   = 1'b0;
        w_is_ill  = 1'b0;
        w_I       = 4'd0;
        w_op1     = w_rs1_val;
        w_op2     = w_zext16;
        w_rd      = r_ir[20:16];
        w_pc_next = w_pc4;
        case (w_opc)
            6'h00: begin
                w_rd  = r_ir[15:11];
                w_I   = w_func[3:0];
                w_op2 = w_rs2_val;
                if (w_func[3:0] == 4'h0 || w_func[3:0] == 4'hF || w_func[10:4] != 7'd0)
                    w_is_ill = 1'b1;
                else
                    w_is_alu = 1'b1;
            end
            6'h08: begin w_is_alu = 1'b1; w_I = 4'd1; w_op2 = w_sext16; end
            6'h0C: begin w_is_alu = 1'b1; w_I = 4'd3; end
            6'h0D: begin w_is_alu = 1'b1; w_I = 4'd4; end
            6'h0E: begin w_is_alu = 1'b1; w_I = 4'd5; end
            6'h0F: begin w_is_alu = 1'b1; w_I = 4'd0; w_op1 = 32'd0; end
            6'h04: begin
                w_is_br = 1'b1;
                if (w_rs1_val == 32'd0) w_pc_next = w_pc4 + w_sext16;
            end
            6'h05: begin
                w_is_br = 1'b1;
                if (w_rs1_val != 32'd0) w_pc_next = w_pc4 + w_sext16;
            end
            6'h02: begin w_is_br = 1'b1; w_pc_next = w_pc4 + w_sext26; end
            6'h3F: ;
            default: w_is_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        alu_ex   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = ~rst;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_alu)     w_next = S_EXEC;
                else if (w_is_br) w_next = S_FETCH;
                else              w_next = S_HALT;
            end
            S_EXEC: begin
                alu_ex = 1'b1;
                w_next = S_WB;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_alu_I   <= 4'd0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: if (imem_ack) r_ir <= imem_rdata;
                S_DECODE: begin
                    if (w_is_alu) begin
                        r_alu_I <= w_I;
                        r_op1   <= w_op1;
                        r_op2   <= w_op2;
                        r_pc    <= w_pc4;
                    end else if (w_is_br) begin
                        r_pc <= w_pc_next;
                    end else if (w_is_ill) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_WB: begin
                    // r0 is never written, so it keeps its reset value of zero.
                    if (w_rd != 5'd0) r_regs[w_rd] <= alu_res;
                    r_flag_c <= alu_carry;
                    r_flag_z <= alu_z;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign alu_I     = r_alu_I;
    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
    assign illegal   = r_illegal;
    assign dbg_data  = r_regs[dbg_addr];
endmodule

// File: doc/dlx_ctrl.md
# dlx_ctrl

Multi-cycle control and decode stage for the DLX core, sitting directly upstream of the ALU. It fetches instructions over a simple request/acknowledge instruction-memory port and decodes them. It reads operands from an internal 32x32 register file, drives the ALU's `I`/`op1`/`op2`/`EX` inputs, and writes the ALU's registered result back to the register file. Branches and jumps are resolved locally without using the ALU.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals PC.
- `imem_ack`  in  1  fetch data valid.
- `imem_rdata`  in  32  instruction word.
- `alu_I`  out  4  ALU operation code.
- `alu_op1`  out  32  ALU operand 1.
- `alu_op2`  out  32  ALU operand 2.
- `alu_ex`  out  1  ALU capture enable.
- `alu_res`  in  32  ALU registered result.
- `alu_carry`  in  1  ALU registered carry.
- `alu_z`  in  1  ALU registered zero flag.
- `flag_c`  out  1  carry captured at the last writeback.
- `flag_z`  out  1  zero flag captured at the last writeback.
- `halted`  out  1  core stopped.
- `illegal`  out  1  stopped on an undefined instruction.
- `dbg_addr`  in  5  debug register-file read address.
- `dbg_data`  out  32  combinational read of `regs[dbg_addr]`.

## Operation
- Reset (async, immediate, including mid-fetch or mid-execute):
  - state=FETCH, PC=`RESET_PC`, IR=0.
  - All 32 registers = 0.
  - `alu_I`=0, `alu_op1`=0, `alu_op2`=0, `alu_ex`=0.
  - `flag_c`=0, `flag_z`=0, `halted`=0, `illegal`=0.
  - `imem_req` is forced 0 while `rst`=1; any fetch in flight is abandoned.
- Instruction fields:
  - opcode = IR[31:26], rs1 = IR[25:21].
  - R-type: rs2 = IR[20:16], rd = IR[15:11], func = IR[10:0].
  - I-type: rd = IR[20:16], imm16 = IR[15:0].
  - J-type: off26 = IR[25:0].
- Decode table:
  - opcode 0x00, R-type:
    - `alu_I` = func[3:0]; `op1` = regs[rs1]; `op2` = regs[rs2].
    - func[3:0] of 0 or 15, or func[10:4] ≠ 0, is illegal.
  - 0x08 ADDI: I=1, op2 = sign-extended imm16.
  - 0x0C ANDI (I=3), 0x0D ORI (I=4), 0x0E XORI (I=5): op2 = zero-extended imm16.
  - 0x0F LHI: I=0, op1=0, op2 = zero-extended imm16.
  - 0x04 BEQZ / 0x05 BNEZ:
    - Condition tested: regs[rs1]==0 (BEQZ) or regs[rs1]≠0 (BNEZ).
    - If taken, PC ← PC+4+sext(imm16); otherwise PC ← PC+4.
  - 0x02 J: PC ← PC+4+sext(off26).
  - 0x3F HALT: enter HALT.
  - Any other opcode is illegal.
- FSM states:
  - FETCH:
    - `imem_req`=1, `imem_addr`=PC.
    - On a clock edge with `imem_ack`=1, IR ← `imem_rdata` and go to DECODE.
    - Otherwise stay in FETCH and hold `imem_req`.
  - DECODE:
    - ALU ops: register `alu_I`/`op1`/`op2`, set PC ← PC+4, go to EXEC.
    - Branch/jump: update PC as above, go to FETCH.
    - HALT opcode: `halted`←1, go to HALT.
    - Illegal: `halted`←1, `illegal`←1, go to HALT. PC is not advanced.
  - EXEC: `alu_ex`=1 for exactly this cycle; `alu_I`/`op1`/`op2` held stable. Go to WB.
  - WB:
    - regs[rd] ← `alu_res`, unless rd==0 (r0 always reads 0).
    - `flag_c` ← `alu_carry`, `flag_z` ← `alu_z`.
    - Go to FETCH.
  - HALT: terminal; only reset leaves it. `imem_req`=0, `alu_ex`=0.
- Register reads in DECODE see writes from the preceding WB, because there is at least one FETCH cycle in between.
- PC arithmetic is modulo 2^32; wrap-around from 0xFFFF_FFFC to 0 is legal.

## Timing
- `alu_ex`, `imem_req` and `halted` are decoded from state; ALU operand outputs are registered.
- Latency with `imem_ack` asserted in the same cycle as `imem_req`:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch/jump: 2 cycles.
  - HALT/illegal: `halted` goes to 1 on the edge that ends DECODE.
- Each memory wait cycle adds one cycle in FETCH. `imem_addr` is stable while `imem_req`=1.
- ALU result timing: the ALU captures on the edge ending EXEC, and the result is valid in WB.
- `alu_ex` is never asserted in consecutive cycles.

## Test plan
- Reset then ADDI 0x20010005 at PC 0, zero-wait memory:
  - `alu_I`=1, `op1`=0, `op2`=5 during EXEC; `alu_ex` pulses once.
  - r1=5 four cycles after the first fetch; the next `imem_addr`=4.
- Sequence ADDI r1←0xFFFF (0x2001FFFF), ADDI r2←1 (0x20020001), ADD r3,r1,r2 (0x00221801):
  - r1=0xFFFF_FFFF and r3=0.
  - `flag_c`=1 and `flag_z`=1 after the ADD writeback.
- LHI 0x3C041234: r4=0x1234_0000. An ALU instruction with rd=0 leaves `dbg_data`@0 equal to 0.
- Branches:
  - BEQZ 0x10000008 at PC 0x10: next fetch at 0x1C, no `alu_ex` pulse.
  - BNEZ on r0 (0x14000008) at PC 0x10: next fetch at 0x14.
  - J with off26 = 0x3FFFFFC at PC 0x8: next fetch at 0x8.
- Memory wait and mid-fetch reset:
  - `imem_ack` held low 3 cycles: `imem_req` stays 1 and `imem_addr` stays stable.
  - `rst` pulsed mid-fetch: `imem_req` drops immediately, then fetch resumes at `RESET_PC`.
- Termination:
  - 0xF8000000 → `illegal`=1, `halted`=1, PC unchanged.
  - 0xFC000000 → `halted`=1, `illegal`=0.
  - In both cases no further `imem_req` until reset.
